// File: rtl/fir_mdc_engine_pkg.sv
// Shared types and constants for the fir_mdc streaming engine and its control FSM.
package fir_mdc_engine_pkg;

  localparam int unsigned FIR_MDC_DATA_W = 32;
  localparam int unsigned FIR_MDC_CNT_W  = 16;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_RUN  = 2'd1,
    ENG_DONE = 2'd2
  } eng_state_e;

  typedef struct packed {
    logic                      clear;
    logic                      enable;
    logic                      start;
    logic [FIR_MDC_CNT_W-1:0]  cnt_limit_y_V;
    logic [FIR_MDC_DATA_W-1:0] coeff_0_V;
    logic [FIR_MDC_DATA_W-1:0] coeff_1_V;
    logic [FIR_MDC_DATA_W-1:0] coeff_2_V;
    logic [FIR_MDC_DATA_W-1:0] coeff_3_V;
  } ctrl_engine_t;

  typedef struct packed {
    logic                     ready;
    logic                     done;
    logic [FIR_MDC_CNT_W-1:0] cnt_y_V;
  } flags_engine_t;

endpackage

// File: rtl/fir_mdc_engine_if.sv
// Source (x_V) and sink (y_V) valid/ready streams of the fir_mdc engine.
interface fir_mdc_engine_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] x_V_data;
  logic              x_V_valid;
  logic              x_V_ready;
  logic [DATA_W-1:0] y_V_data;
  logic              y_V_valid;
  logic              y_V_ready;

  // Master is the streamer side feeding x and draining y; slave is the engine.
  modport master (
    output x_V_data, x_V_valid, y_V_ready,
    input  x_V_ready, y_V_data, y_V_valid
  );

  modport slave (
    input  x_V_data, x_V_valid, y_V_ready,
    output x_V_ready, y_V_data, y_V_valid
  );
endinterface

// File: rtl/fir_mdc_engine_mac4.sv
// Combinational 4-tap signed multiply-accumulate with arithmetic shift and wrap-around truncation.
module fir_mdc_engine_mac4
  import fir_mdc_engine_pkg::*;
#(
  parameter int unsigned DATA_W    = FIR_MDC_DATA_W,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] d0_i,
  input  logic [DATA_W-1:0] d1_i,
  input  logic [DATA_W-1:0] d2_i,
  input  logic [DATA_W-1:0] c0_i,
  input  logic [DATA_W-1:0] c1_i,
  input  logic [DATA_W-1:0] c2_i,
  input  logic [DATA_W-1:0] c3_i,
  output logic [DATA_W-1:0] y_o
);

  localparam int unsigned PW = 2 * DATA_W;
  localparam int unsigned AW = 2 * DATA_W + 2;

  logic signed [PW-1:0] p0, p1, p2, p3;
  logic signed [AW-1:0] acc;

  // Operands are sign-extended to full product width so no partial product is lost.
  always_comb begin
    p0  = PW'(signed'(x_i))  * PW'(signed'(c0_i));
    p1  = PW'(signed'(d0_i)) * PW'(signed'(c1_i));
    p2  = PW'(signed'(d1_i)) * PW'(signed'(c2_i));
    p3  = PW'(signed'(d2_i)) * PW'(signed'(c3_i));
    acc = AW'(p0) + AW'(p1) + AW'(p2) + AW'(p3);
    y_o = DATA_W'(acc >>> OUT_SHIFT);
  end

endmodule

// File: rtl/fir_mdc_engine.sv
// fir_mdc streaming engine: control FSM, 3-deep delay line, registered output and output counter.
module fir_mdc_engine
  import fir_mdc_engine_pkg::*;
#(
  parameter int unsigned DATA_W    = FIR_MDC_DATA_W,
  parameter int unsigned CNT_W     = FIR_MDC_CNT_W,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              ctrl_clear_i,
  input  logic              ctrl_enable_i,
  input  logic              ctrl_start_i,
  input  logic [CNT_W-1:0]  cnt_limit_y_V_i,
  input  logic [DATA_W-1:0] coeff_0_V_i,
  input  logic [DATA_W-1:0] coeff_1_V_i,
  input  logic [DATA_W-1:0] coeff_2_V_i,
  input  logic [DATA_W-1:0] coeff_3_V_i,
  fir_mdc_engine_if.slave   stream,
  output logic              ready_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cnt_y_V_o
);

  eng_state_e        state_q, state_d;
  logic [DATA_W-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic [DATA_W-1:0] y_data_q, y_data_d, mac_y;
  logic              y_valid_q, y_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, issued_q, issued_d;
  logic              clr, start_go, accept, handoff, last_handoff, x_ready;

  assign clr          = clear_i | ctrl_clear_i;
  assign start_go     = (state_q == ENG_IDLE) & ctrl_start_i & ctrl_enable_i;
  assign handoff      = y_valid_q & stream.y_V_ready;
  assign accept       = stream.x_V_valid & x_ready;
  assign last_handoff = handoff & ((cnt_q + CNT_W'(1)) == cnt_limit_y_V_i);

  fir_mdc_engine_mac4 #(
    .DATA_W    (DATA_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac4 (
    .x_i  (stream.x_V_data),
    .d0_i (d0_q),
    .d1_i (d1_q),
    .d2_i (d2_q),
    .c0_i (coeff_0_V_i),
    .c1_i (coeff_1_V_i),
    .c2_i (coeff_2_V_i),
    .c3_i (coeff_3_V_i),
    .y_o  (mac_y)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ENG_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ENG_IDLE;
    end else begin
      unique case (state_q)
        ENG_IDLE: if (start_go) state_d = (cnt_limit_y_V_i == '0) ? ENG_DONE : ENG_RUN;
        ENG_RUN:  if (last_handoff) state_d = ENG_DONE;
        ENG_DONE: state_d = ENG_IDLE;
        default:  state_d = ENG_IDLE;
      endcase
    end
  end

  // Clear also masks x ready so a sample is never consumed and then dropped by the clear.
  always_comb begin
    ready_o = (state_q == ENG_IDLE);
    done_o  = (state_q == ENG_DONE);
    x_ready = (state_q == ENG_RUN) & ~clr & ctrl_enable_i
            & (~y_valid_q | stream.y_V_ready) & (issued_q < cnt_limit_y_V_i);
  end

  always_comb begin
    d0_d      = d0_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    cnt_d     = cnt_q;
    issued_d  = issued_q;
    if (clr) begin
      d0_d      = '0;
      d1_d      = '0;
      d2_d      = '0;
      y_data_d  = '0;
      y_valid_d = 1'b0;
      cnt_d     = '0;
      issued_d  = '0;
    end else begin
      if (start_go) begin
        d0_d     = '0;
        d1_d     = '0;
        d2_d     = '0;
        cnt_d    = '0;
        issued_d = '0;
      end
      // An accept in the same cycle as a handoff reloads the register and keeps valid high.
      if (accept) begin
        d2_d      = d1_q;
        d1_d      = d0_q;
        d0_d      = stream.x_V_data;
        y_data_d  = mac_y;
        y_valid_d = 1'b1;
        issued_d  = issued_q + CNT_W'(1);
      end else if (handoff) begin
        y_valid_d = 1'b0;
      end
      if (handoff) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the delay line is a handful of flops, not a RAM, so it is reset along with the rest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d0_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      cnt_q     <= '0;
      issued_q  <= '0;
    end else begin
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      cnt_q     <= cnt_d;
      issued_q  <= issued_d;
    end
  end

  assign stream.x_V_ready = x_ready;
  assign stream.y_V_data  = y_data_q;
  assign stream.y_V_valid = y_valid_q;
  assign cnt_y_V_o        = cnt_q;

endmodule

// File: tb/tb_fir_mdc_engine.sv
// Scoreboard bench for fir_mdc_engine: directed streams, expected outputs queued at issue time.
module tb_fir_mdc_engine;
  import fir_mdc_engine_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          ctrl_clear = 1'b0;
  logic          ctrl_enable = 1'b0;
  logic          ctrl_start = 1'b0;
  logic [CW-1:0] limit = '0;
  logic [DW-1:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0;
  logic          ready, done;
  logic [CW-1:0] cnt;

  fir_mdc_engine_if #(.DATA_W(DW)) strm ();

  fir_mdc_engine #(
    .DATA_W    (DW),
    .CNT_W     (CW),
    .OUT_SHIFT (0)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .ctrl_clear_i    (ctrl_clear),
    .ctrl_enable_i   (ctrl_enable),
    .ctrl_start_i    (ctrl_start),
    .cnt_limit_y_V_i (limit),
    .coeff_0_V_i     (c0),
    .coeff_1_V_i     (c1),
    .coeff_2_V_i     (c2),
    .coeff_3_V_i     (c3),
    .stream          (strm),
    .ready_o         (ready),
    .done_o          (done),
    .cnt_y_V_o       (cnt)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake is matched against the next queued expectation.
  always @(negedge clk) begin
    if (rst_ni && strm.y_V_valid && strm.y_V_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", strm.y_V_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("y_data", strm.y_V_data, mon_e.data);
        check("y_cnt", cnt, mon_e.cnt);
      end
    end
  end

  task automatic expect_y(input logic [DW-1:0] d, input logic [CW-1:0] n);
    exp_t e;
    e.data = d;
    e.cnt  = n;
    sb_q.push_back(e);
  endtask

  task automatic set_coeffs(input logic [DW-1:0] a, b, c, d);
    c0 = a; c1 = b; c2 = c; c3 = d;
  endtask

  task automatic start_run(input logic [CW-1:0] lim);
    limit       = lim;
    ctrl_enable = 1'b1;
    ctrl_start  = 1'b1;
    @(posedge clk); #1;
    ctrl_start  = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] v);
    bit acc = 1'b0;
    strm.x_V_valid = 1'b1;
    strm.x_V_data  = v;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = strm.x_V_ready;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept data=%0h", v);
    end
    strm.x_V_valid = 1'b0;
  endtask

  task automatic expect_impulse();
    expect_y(32'd1, 16'd0);
    expect_y(32'd2, 16'd1);
    expect_y(32'd3, 16'd2);
    expect_y(32'd4, 16'd3);
    expect_y(32'd0, 16'd4);
  endtask

  // Waits for the done pulse after the last accepted sample and checks the wrap-up.
  task automatic finish_run(input logic [CW-1:0] n);
    int waited = 0;
    bit seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      waited++;
      seen = done;
    end
    check("done_seen", seen, 1);
    check("done_latency", waited, 2);
    check("cnt_final", cnt, n);
    check("sb_drained", sb_q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("ready_after", ready, 1);
    check("cnt_hold", cnt, n);
    @(posedge clk); #1;
  endtask

  initial begin
    strm.x_V_valid = 1'b0;
    strm.x_V_data  = '0;
    strm.y_V_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_x_ready", strm.x_V_ready, 0);
    check("rst_y_valid", strm.y_V_valid, 0);
    check("rst_y_data", strm.y_V_data, 0);
    check("rst_cnt", cnt, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // Start without enable must be ignored.
    limit       = 16'd5;
    ctrl_enable = 1'b0;
    ctrl_start  = 1'b1;
    @(posedge clk); #1;
    ctrl_start  = 1'b0;
    @(negedge clk);
    check("start_no_enable", ready, 1);
    @(posedge clk); #1;

    // Impulse response.
    set_coeffs(32'd1, 32'd2, 32'd3, 32'd4);
    start_run(16'd5);
    expect_impulse();
    send(32'd1);
    for (int i = 0; i < 4; i++) send(32'd0);
    finish_run(16'd5);

    // Backpressure on the first output.
    strm.y_V_ready = 1'b0;
    start_run(16'd5);
    expect_impulse();
    send(32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_x_ready", strm.x_V_ready, 0);
      check("bp_y_valid", strm.y_V_valid, 1);
      check("bp_y_data", strm.y_V_data, 1);
      @(posedge clk); #1;
    end
    strm.y_V_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(32'd0);
    finish_run(16'd5);

    // Wrap: -1 * most negative value.
    set_coeffs(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0);
    start_run(16'd1);
    expect_y(32'h8000_0000, 16'd0);
    send(32'h8000_0000);
    finish_run(16'd1);

    // Wrap: max positive squared, then twice that.
    set_coeffs(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0);
    start_run(16'd2);
    expect_y(32'd1, 16'd0);
    expect_y(32'd2, 16'd1);
    send(32'h7FFF_FFFF);
    send(32'h7FFF_FFFF);
    finish_run(16'd2);

    // Zero limit goes straight to DONE.
    limit       = 16'd0;
    ctrl_start  = 1'b1;
    strm.x_V_valid = 1'b1;
    strm.x_V_data  = 32'd9;
    @(posedge clk); #1;
    ctrl_start  = 1'b0;
    @(negedge clk);
    check("l0_done", done, 1);
    check("l0_ready", ready, 0);
    check("l0_x_ready", strm.x_V_ready, 0);
    check("l0_cnt", cnt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("l0_done_end", done, 0);
    check("l0_ready_after", ready, 1);
    check("l0_x_ready_after", strm.x_V_ready, 0);
    @(posedge clk); #1;
    strm.x_V_valid = 1'b0;

    // Enable stall mid-run with a pending output.
    set_coeffs(32'd3, 32'hFFFF_FFFE, 32'd5, 32'd7);
    start_run(16'd4);
    expect_y(32'd6, 16'd0);
    expect_y(32'hFFFF_FFF9, 16'd1);
    expect_y(32'd24, 16'd2);
    expect_y(32'd31, 16'd3);
    send(32'd2);
    send(32'hFFFF_FFFF);
    ctrl_enable    = 1'b0;
    strm.x_V_valid = 1'b1;
    strm.x_V_data  = 32'd4;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_x_ready", strm.x_V_ready, 0);
      if (i == 3) check("stall_drained", strm.y_V_valid, 0);
      @(posedge clk); #1;
    end
    ctrl_enable = 1'b1;
    send(32'd4);
    send(32'd10);
    finish_run(16'd4);

    // Clear after two outputs, then a fresh impulse run.
    set_coeffs(32'd1, 32'd2, 32'd3, 32'd4);
    start_run(16'd5);
    expect_y(32'd1, 16'd0);
    expect_y(32'd2, 16'd1);
    send(32'd1);
    send(32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("clr_pre_cnt", cnt, 2);
    check("clr_pre_ready", ready, 0);
    @(posedge clk); #1;
    ctrl_clear = 1'b1;
    @(posedge clk); #1;
    ctrl_clear = 1'b0;
    @(negedge clk);
    check("clr_ready", ready, 1);
    check("clr_cnt", cnt, 0);
    check("clr_y_valid", strm.y_V_valid, 0);
    check("clr_y_data", strm.y_V_data, 0);
    check("clr_x_ready", strm.x_V_ready, 0);
    @(posedge clk); #1;
    start_run(16'd5);
    expect_impulse();
    send(32'd1);
    for (int i = 0; i < 4; i++) send(32'd0);
    finish_run(16'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
